// File: rtl/mfp_showahead_fifo.sv
// ---------------------------------------------------------------------------
// mfp_showahead_fifo -- show-ahead (first-word fall-through) FIFO.
//
// Storage is a simple dual-port RAM (mfp_dual_port_mem, defined below).
// The RAM's registered read port doubles as the head-of-queue output stage.
// head_valid marks when that stage holds a live entry. A read is launched
// whenever the RAM holds unread data and the head is empty or being popped.
// This gives back-to-back pops with no bubble.
//
// Parameters:
//   ADDR_WIDTH  log2 of depth (DEPTH = 2**ADDR_WIDTH)
//   DATA_WIDTH  entry width in bits
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        synchronous active-high reset
//   push       write request; refused while full
//   push_data  data to write
//   full       count == DEPTH
//   pop        consume head entry; ignored while empty
//   pop_data   head entry, valid when empty == 0 (0 while empty)
//   empty      no head entry presented
//   count      accepted entries not yet popped (includes the head)
//   overflow   one-cycle pulse: push refused because full
//   underflow  one-cycle pulse: pop while empty
// ---------------------------------------------------------------------------

// Simple dual-port RAM: synchronous write, registered read (1-cycle latency).
// The read-data register holds its value when no read is requested.
module mfp_dual_port_mem #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);
    logic [DATA_WIDTH-1:0] r_mem [0:(1<<ADDR_WIDTH)-1];
    logic [DATA_WIDTH-1:0] r_rd_data;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
        if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;
endmodule

module mfp_showahead_fifo #(
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    output logic                  full,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] pop_data,
    output logic                  empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam logic [ADDR_WIDTH:0] LP_DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_mem_count;
    logic [ADDR_WIDTH:0]   r_count;
    logic                  r_head_valid;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_full;
    logic                  w_push_ok;
    logic                  w_pop_ok;
    logic                  w_rd_en;
    logic [DATA_WIDTH-1:0] w_rd_data;
    logic [ADDR_WIDTH:0]   w_mem_count_nxt;
    logic [ADDR_WIDTH:0]   w_count_nxt;

    assign w_full    = (r_count == LP_DEPTH);
    assign w_push_ok = push && !w_full;
    assign w_pop_ok  = pop && r_head_valid;

    // r_mem_count only covers entries written on earlier edges, so a read
    // never targets the slot being written this cycle.
    assign w_rd_en = (r_mem_count != '0) && (!r_head_valid || w_pop_ok);

    always_comb begin
        w_mem_count_nxt = r_mem_count;
        if (w_push_ok && !w_rd_en)
            w_mem_count_nxt = r_mem_count + (ADDR_WIDTH+1)'(1);
        else if (!w_push_ok && w_rd_en)
            w_mem_count_nxt = r_mem_count - (ADDR_WIDTH+1)'(1);

        w_count_nxt = r_count;
        if (w_push_ok && !w_pop_ok)
            w_count_nxt = r_count + (ADDR_WIDTH+1)'(1);
        else if (!w_push_ok && w_pop_ok)
            w_count_nxt = r_count - (ADDR_WIDTH+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_mem_count  <= '0;
            r_count      <= '0;
            r_head_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + ADDR_WIDTH'(1);
            if (w_rd_en)   r_rd_ptr <= r_rd_ptr + ADDR_WIDTH'(1);
            r_mem_count <= w_mem_count_nxt;
            r_count     <= w_count_nxt;
            // A read lands in the output stage at this edge; otherwise a pop
            // with nothing to refill leaves the stage empty.
            if (w_rd_en)
                r_head_valid <= 1'b1;
            else if (w_pop_ok)
                r_head_valid <= 1'b0;
            r_overflow  <= push && w_full;
            r_underflow <= pop && !r_head_valid;
        end
    end

    mfp_dual_port_mem #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mem (
        .i_clk     (clk),
        .i_wr_en   (w_push_ok && !rst),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (push_data),
        .i_rd_en   (w_rd_en && !rst),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_rd_data)
    );

    // The RAM read register is not reset; masking with head_valid gives a
    // zero head while empty (including straight out of reset).
    assign pop_data  = r_head_valid ? w_rd_data : '0;
    assign empty     = !r_head_valid;
    assign full      = w_full;
    assign count     = r_count;
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
endmodule

// File: tb/tb_mfp_showahead_fifo.sv
// ---------------------------------------------------------------------------
// tb_mfp_showahead_fifo -- self-checking bench for mfp_showahead_fifo.
// Reference model: a queue of accepted entries plus one rule for visibility.
// The head is presented after an edge iff some entry accepted on an earlier
// edge remains after that edge's pop.
// ---------------------------------------------------------------------------
module tb_mfp_showahead_fifo;
    localparam int unsigned AW    = 6;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [DW-1:0] push_data = '0;
    logic [DW-1:0] pop_data;
    logic          full, empty, overflow, underflow;
    logic [AW:0]   count;

    int unsigned   n_vec = 0;
    int unsigned   n_miscmp = 0;

    logic [DW-1:0] mq[$];
    bit            mhv = 1'b0;

    always #5 clk = ~clk;

    mfp_showahead_fifo #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .full      (full),
        .pop       (pop),
        .pop_data  (pop_data),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miscmp++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock: apply inputs, advance the model at the edge, check #1 later.
    task automatic step(input logic r, input logic p, input logic q, input logic [DW-1:0] d);
        int unsigned sz;
        bit          pop_ok, push_ok, exp_ov, exp_un;
        rst = r; push = p; pop = q; push_data = d;
        @(posedge clk);
        sz = mq.size();
        if (r) begin
            mq.delete();
            mhv = 1'b0; exp_ov = 1'b0; exp_un = 1'b0;
        end else begin
            pop_ok  = q && mhv;
            push_ok = p && (sz < DEPTH);
            exp_ov  = p && (sz == DEPTH);
            exp_un  = q && !mhv;
            mhv     = (sz - (pop_ok ? 1 : 0)) != 0;
            if (pop_ok)  void'(mq.pop_front());
            if (push_ok) mq.push_back(d);
        end
        #1;
        chk("empty",     32'(empty),     32'(!mhv));
        chk("count",     32'(count),     32'(mq.size()));
        chk("full",      32'(full),      32'(mq.size() == DEPTH));
        chk("overflow",  32'(overflow),  32'(exp_ov));
        chk("underflow", 32'(underflow), 32'(exp_un));
        chk("pop_data",  32'(pop_data),  mhv ? 32'(mq[0]) : 32'd0);
    endtask

    task automatic drain();
        int unsigned guard = 0;
        while (mq.size() != 0 && guard < 4 * DEPTH) begin
            step(1'b0, 1'b0, 1'b1, '0);
            guard++;
        end
        chk("drain_done", 32'(mq.size()), 32'd0);
    endtask

    initial begin
        logic [DW-1:0] pat;

        // reset state
        step(1'b1, 1'b0, 1'b0, '0);
        step(1'b1, 1'b1, 1'b1, 8'h11);

        // single word: visible one edge after the accepting edge
        step(1'b0, 1'b1, 1'b0, 8'hA5);
        chk("single_not_yet", 32'(empty), 32'd1);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("single_head", 32'(pop_data), 32'hA5);
        step(1'b0, 1'b0, 1'b1, '0);
        chk("single_popped", 32'(count), 32'd0);

        // fill to DEPTH, one refused push, drain in order
        for (int i = 0; i < int'(DEPTH); i++) step(1'b0, 1'b1, 1'b0, DW'(i));
        chk("fill_full", 32'(full), 32'd1);
        step(1'b0, 1'b1, 1'b0, 8'hEE);
        chk("fill_ovf", 32'(overflow), 32'd1);
        drain();

        // streaming: 3 prefilled, push+pop together for 200 cycles
        pat = '0;
        for (int i = 0; i < 3; i++) begin step(1'b0, 1'b1, 1'b0, pat); pat++; end
        step(1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 200; i++) begin step(1'b0, 1'b1, 1'b1, pat); pat++; end
        chk("stream_count", 32'(count), 32'd3);
        drain();

        // wrap: 10 rounds of 50 words
        for (int r = 0; r < 10; r++) begin
            for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'b0, DW'($urandom));
            drain();
            step(1'b0, 1'b0, 1'b0, '0);
            chk("wrap_empty", 32'(empty), 32'd1);
        end

        // underflow, then push+pop while full
        step(1'b0, 1'b0, 1'b1, '0);
        chk("unf_pulse", 32'(underflow), 32'd1);
        for (int i = 0; i < int'(DEPTH); i++) step(1'b0, 1'b1, 1'b0, DW'($urandom));
        step(1'b0, 1'b1, 1'b1, 8'h77);
        chk("full_pp_count", 32'(count), 32'(DEPTH - 1));
        drain();

        // reset mid-operation
        for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'b0, DW'(i + 100));
        step(1'b1, 1'b1, 1'b1, 8'h55);
        chk("rst_mid_count", 32'(count), 32'd0);
        step(1'b0, 1'b1, 1'b0, 8'h3C);
        step(1'b0, 1'b0, 1'b0, '0);
        chk("rst_mid_head", 32'(pop_data), 32'h3C);
        drain();

        // random traffic, biased to visit both full and empty
        for (int i = 0; i < 1500; i++) begin
            int unsigned bias = (i / 300) % 2;
            logic p = ($urandom_range(0, 99) < (bias ? 70 : 35));
            logic q = ($urandom_range(0, 99) < (bias ? 35 : 70));
            step(($urandom_range(0, 499) == 0), p, q, DW'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end
endmodule
